reg_query_responder: RTL and testbench
======================================

Name: reg_query_responder

Overview:
- Responder end of the register query bus. Each cycle it accepts up to two rename queries from the front end (arch rs_1/rs_2/rd, rename request, speculative tag).
- Returns, one cycle later, the rename tags (rn) currently producing rs_1/rs_2, plus a freshly allocated rn for rd.
- Owns the architectural-to-rename map, the free-tag bitmap and a single speculation checkpoint.
- Sits between the renamer and the reservation stations; commits arrive from the reorder buffer.

Parameters:
- ARCH_REGS, 32, architectural register count; index width 5.
- RN_TAGS, 64, rename tag space; width 6; rn 0 is reserved and means "no pending producer, read architectural file".

Ports:
- clock  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-low reset.
- q_valid[2]  in  1 each  Query i present.
- q_rs_1[2], q_rs_2[2], q_rd[2]  in  5 each  Architectural sources/destination.
- q_rename[2]  in  1 each  Allocate an rn for q_rd.
- q_tag[2]  in  1 each  Query issued under unresolved branch.
- r_valid[2]  out  1 each  Response i valid.
- r_rs_1_rn[2], r_rs_2_rn[2], r_rd_rn[2]  out  6 each  Renamed operands; 0 = no rename.
- full  out  1  Insufficient free tags; renamer must hold.
- commit_valid[2]  in  1 each  ROB retires entry.
- commit_rd[2]  in  5 each  Retired destination.
- commit_rn[2]  in  6 each  Retired tag.
- tag_set  in  1  Branch entered speculation; take checkpoint.
- tag_clear  in  1  Branch resolved correct.
- flush  in  1  Branch mispredicted; roll back.

Behaviour:
- Reset (reset=0, async): map all 0, busy bitmap = only rn0 set, spec_alloc = 0, checkpoint cleared, every output 0.
- State:
  - map[32] x 6 bits; busy[64] bitmap; spec_alloc[64] = rn allocated with q_tag=1; snap_map[32]; snap_valid.
- Latency: responses registered, 1 cycle after the query edge. r_valid = q_valid delayed, forced 0 when the request was refused.
- Lookup: r_rs_x_rn = map[rs_x] as it stood before this cycle's updates. Arch reg x0 always returns 0 and is never renamed; a rename of rd=0 allocates nothing and returns r_rd_rn=0.
- Intra-pair forwarding: if query0 renames rd=k≠0 and query1 reads k, query1 gets query0's new rn.
- Same-rd case: if both rename the same rd, map ends with query1's rn.
- Allocation: lowest free rn to query0, next lowest to query1; set busy. If the q_tag bit is 1, also set spec_alloc.
- Insufficient tags:
  - full = fewer free tags than renames requested this cycle; combinational from busy and the request.
  - When full, neither query is accepted: no map/busy change, r_valid=0 for both next cycle.
  - All-or-nothing; partial acceptance is forbidden.
- Commit, per port:
  - Clear busy[commit_rn] and spec_alloc[commit_rn].
  - If map[commit_rd]==commit_rn, set map entry to 0; apply the same check to snap_map.
  - A commit freeing a tag and an allocation in the same cycle: the freed tag is not reusable until next cycle.
- tag_set: snap_map = map after this cycle's q_tag=0 updates, excluding q_tag=1 updates. Set snap_valid. A second tag_set while snap_valid is ignored (single-level speculation).
- tag_clear: spec_alloc=0, snap_valid=0.
- flush:
  - map=snap_map, busy &= ~spec_alloc, spec_alloc=0, snap_valid=0.
  - Same-cycle queries are refused (r_valid=0 next cycle).
  - Same-cycle commits are still applied.
  - flush with snap_valid=0 is a no-op.
- Priority: reset > flush > tag_clear > tag_set > queries. Commits are applied in every non-reset cycle.
- Reset mid-operation discards all in-flight responses; outputs drop to 0 immediately.

Decomposition:
- Shared package structures gains:
  - rn_t (6-bit tag) and arch_reg_t (5-bit);
  - constant RN_NONE = 6'h0;
  - a query_req_t / query_resp_t struct pair for the bus.
- One natural sub-module: free_tag_allocator. It owns the busy bitmap, spec_alloc, two-lowest-zero priority encoding, full generation and release ports.

Test Plan:
- Reset, then query0 {rs_1=1, rs_2=2, rd=3, rename}: next cycle r_rs_1_rn=0, r_rs_2_rn=0, r_rd_rn=1, r_valid[0]=1.
- Same cycle, query0 rd=5 rename and query1 rs_1=5 rename rd=5: query1 r_rs_1_rn=query0's rn (1), r_rd_rn=2, map[5]=2.
- Allocate until 62 tags are busy, then request two renames: full=1, r_valid=0 for both. Commit one tag, next cycle full=0.
- tag_set with untagged rd=4→rn1, then tagged rd=4→rn2, then flush: map[4]=1, rn2 free, next allocation returns 2.
- Commit rd=6 rn=3 while map[6]=3 → map[6]=0. Commit rd=6 rn=3 while map[6]=7 → map[6] stays 7, tag 3 freed.
- Assert reset low mid-burst with responses pending: all r_valid=0 and full=0 asynchronously. After release, the first allocation is rn1.

Source files
------------

// File: rtl/reg_query_responder_pkg.sv
// Shared types for the register query bus: tags, arch indices and
// the request/response bundles exchanged with the renamer.
package reg_query_responder_pkg;

   localparam int ARCH_REGS = 32;
   localparam int RN_TAGS   = 64;
   localparam int AW        = $clog2(ARCH_REGS);
   localparam int RW        = $clog2(RN_TAGS);

   typedef logic [AW-1:0]      arch_reg_t;
   typedef logic [RW-1:0]      rn_t;
   typedef logic [RN_TAGS-1:0] rn_mask_t;

   localparam rn_t RN_NONE = 6'h0;

   typedef struct packed {
      logic      valid;
      arch_reg_t rs_1;
      arch_reg_t rs_2;
      arch_reg_t rd;
      logic      rename;
      logic      tag;
   } query_req_t;

   typedef struct packed {
      logic valid;
      rn_t  rs_1_rn;
      rn_t  rs_2_rn;
      rn_t  rd_rn;
   } query_resp_t;

   typedef struct packed {
      logic found;
      rn_t  rn;
   } free_pick_t;

   function automatic free_pick_t pick_free(rn_mask_t busy);
      free_pick_t p;
      p = '0;
      for (int i = RN_TAGS - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            p.found = 1'b1;
            p.rn    = rn_t'(i);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/reg_query_responder_if.sv
// Two-lane register query bus between the renamer (master)
// and the query responder (slave).
interface reg_query_responder_if;
   import reg_query_responder_pkg::*;

   logic      q_valid   [2];
   arch_reg_t q_rs_1    [2];
   arch_reg_t q_rs_2    [2];
   arch_reg_t q_rd      [2];
   logic      q_rename  [2];
   logic      q_tag     [2];
   logic      r_valid   [2];
   rn_t       r_rs_1_rn [2];
   rn_t       r_rs_2_rn [2];
   rn_t       r_rd_rn   [2];
   logic      full;

   modport master (
      output q_valid, q_rs_1, q_rs_2, q_rd, q_rename, q_tag,
      input  r_valid, r_rs_1_rn, r_rs_2_rn, r_rd_rn, full
   );

   modport slave (
      input  q_valid, q_rs_1, q_rs_2, q_rd, q_rename, q_tag,
      output r_valid, r_rs_1_rn, r_rs_2_rn, r_rd_rn, full
   );

endinterface

// File: rtl/reg_query_responder_free_tag_allocator.sv
// Free-tag bitmap with speculative-allocation tracking; hands out the
// two lowest free tags per cycle and raises full when short.
module reg_query_responder_free_tag_allocator
   import reg_query_responder_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] need,
   input  logic       alloc_en,
   input  logic [1:0] alloc_spec,
   input  logic [1:0] rel_valid,
   input  rn_t        rel_rn [2],
   input  logic       flush,
   input  logic       spec_clear,
   output logic       full,
   output rn_t        alloc_rn [2]
);

   rn_mask_t   busy;
   rn_mask_t   spec;
   rn_mask_t   rel_mask;
   rn_mask_t   alloc_mask;
   rn_mask_t   spec_mask;
   free_pick_t p0;
   free_pick_t p1;

   always_comb begin
      p0 = pick_free(busy);
      p1 = pick_free(busy | (rn_mask_t'(1) << p0.rn));
      full = (|need & ~p0.found) | (&need & ~p1.found);
      alloc_rn[0] = p0.rn;
      alloc_rn[1] = need[0] ? p1.rn : p0.rn;
   end

   always_comb begin
      rel_mask   = '0;
      alloc_mask = '0;
      spec_mask  = '0;
      for (int i = 0; i < 2; i++) begin
         if (rel_valid[i])
            rel_mask[rel_rn[i]] = 1'b1;
         if (alloc_en && !full && need[i]) begin
            alloc_mask[alloc_rn[i]] = 1'b1;
            if (alloc_spec[i])
               spec_mask[alloc_rn[i]] = 1'b1;
         end
      end
   end

   // Tags freed this cycle only become visible to the picker next cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy <= rn_mask_t'(1);
         spec <= '0;
      end else if (flush) begin
         busy <= (busy & ~spec & ~rel_mask) | rn_mask_t'(1);
         spec <= '0;
      end else begin
         busy <= (busy & ~rel_mask) | alloc_mask | rn_mask_t'(1);
         if (spec_clear)
            spec <= '0;
         else
            spec <= (spec & ~rel_mask) | spec_mask;
      end
   end

endmodule

// File: rtl/reg_query_responder.sv
// Register query responder: arch-to-rename map, single checkpoint,
// registered two-lane rename responses.
module reg_query_responder
   import reg_query_responder_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   reg_query_responder_if.slave    bus,
   input  logic                    commit_valid [2],
   input  arch_reg_t               commit_rd    [2],
   input  rn_t                     commit_rn    [2],
   input  logic                    tag_set,
   input  logic                    tag_clear,
   input  logic                    flush
);

   rn_t         map      [ARCH_REGS];
   rn_t         snap_map [ARCH_REGS];
   rn_t         map_c    [ARCH_REGS];
   rn_t         snap_c   [ARCH_REGS];
   rn_t         map_nx   [ARCH_REGS];
   rn_t         snap_nx  [ARCH_REGS];
   logic        snap_valid;
   query_req_t  q      [2];
   query_resp_t rsp    [2];
   query_resp_t rsp_nx [2];
   rn_t         alloc_rn [2];
   logic [1:0]  need;
   logic [1:0]  spec_req;
   logic [1:0]  rel_valid;
   logic        full;
   logic        flush_eff;
   logic        take_snap;
   logic        accept;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         q[i].valid   = bus.q_valid[i];
         q[i].rs_1    = bus.q_rs_1[i];
         q[i].rs_2    = bus.q_rs_2[i];
         q[i].rd      = bus.q_rd[i];
         q[i].rename  = bus.q_rename[i];
         q[i].tag     = bus.q_tag[i];
         need[i]      = q[i].valid & q[i].rename
                      & (q[i].rd != '0);
         spec_req[i]  = q[i].tag;
         rel_valid[i] = commit_valid[i]
                      & (commit_rn[i] != RN_NONE);
      end
   end

   // A flush without a live checkpoint is treated as if absent.
   always_comb begin
      flush_eff = flush & snap_valid;
      take_snap = tag_set & ~snap_valid
                & ~flush_eff & ~tag_clear;
      accept    = ~full & ~flush_eff;
   end

   reg_query_responder_free_tag_allocator u_alloc (
      .clock      (clock),
      .reset      (reset),
      .need       (need),
      .alloc_en   (~flush_eff),
      .alloc_spec (spec_req),
      .rel_valid  (rel_valid),
      .rel_rn     (commit_rn),
      .flush      (flush_eff),
      .spec_clear (tag_clear),
      .full       (full),
      .alloc_rn   (alloc_rn)
   );

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rsp_nx[i] = '0;
         if (q[i].valid && accept) begin
            rsp_nx[i].valid   = 1'b1;
            rsp_nx[i].rs_1_rn = map[q[i].rs_1];
            rsp_nx[i].rs_2_rn = map[q[i].rs_2];
            rsp_nx[i].rd_rn   = need[i] ? alloc_rn[i] : RN_NONE;
         end
      end
      if (rsp_nx[1].valid && need[0]) begin
         if (q[1].rs_1 == q[0].rd)
            rsp_nx[1].rs_1_rn = alloc_rn[0];
         if (q[1].rs_2 == q[0].rd)
            rsp_nx[1].rs_2_rn = alloc_rn[0];
      end
   end

   // Commits retire a producer only if it is still the latest one mapped.
   always_comb begin
      map_c  = map;
      snap_c = snap_map;
      for (int p = 0; p < 2; p++) begin
         if (rel_valid[p]) begin
            if (map_c[commit_rd[p]] == commit_rn[p])
               map_c[commit_rd[p]] = RN_NONE;
            if (snap_c[commit_rd[p]] == commit_rn[p])
               snap_c[commit_rd[p]] = RN_NONE;
         end
      end
      map_nx = map_c;
      if (take_snap)
         snap_nx = map_c;
      else
         snap_nx = snap_c;
      if (accept) begin
         for (int i = 0; i < 2; i++) begin
            if (need[i]) begin
               map_nx[q[i].rd] = alloc_rn[i];
               if (take_snap && !q[i].tag)
                  snap_nx[q[i].rd] = alloc_rn[i];
            end
         end
      end
      if (flush_eff)
         map_nx = snap_c;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            map[i]      <= RN_NONE;
            snap_map[i] <= RN_NONE;
         end
         snap_valid <= 1'b0;
         rsp[0]     <= '0;
         rsp[1]     <= '0;
      end else begin
         map      <= map_nx;
         snap_map <= snap_nx;
         rsp      <= rsp_nx;
         if (flush_eff || tag_clear)
            snap_valid <= 1'b0;
         else if (take_snap)
            snap_valid <= 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         bus.r_valid[i]   = rsp[i].valid;
         bus.r_rs_1_rn[i] = rsp[i].rs_1_rn;
         bus.r_rs_2_rn[i] = rsp[i].rs_2_rn;
         bus.r_rd_rn[i]   = rsp[i].rd_rn;
      end
      bus.full = full;
   end

endmodule

// File: tb/tb_reg_query_responder.sv
// Bench for reg_query_responder: directed scenarios plus random traffic
// checked against an array/queue model of the rename rules.
module tb_reg_query_responder;
   import reg_query_responder_pkg::*;

   logic      clock = 1'b0;
   logic      reset = 1'b0;
   logic      commit_valid [2];
   arch_reg_t commit_rd    [2];
   rn_t       commit_rn    [2];
   logic      tag_set, tag_clear, flush;
   int        errors = 0;
   int        checks = 0;

   reg_query_responder_if bus ();

   reg_query_responder dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_rn    (commit_rn),
      .tag_set      (tag_set),
      .tag_clear    (tag_clear),
      .flush        (flush)
   );

   always #5 clock = ~clock;

   rn_t       m_map   [ARCH_REGS];
   rn_t       m_snap  [ARCH_REGS];
   bit        m_busy  [RN_TAGS];
   bit        m_spec  [RN_TAGS];
   arch_reg_t m_owner [RN_TAGS];
   bit        m_snap_valid;
   logic      e_full;
   logic      e_rv  [2];
   rn_t       e_rs1 [2];
   rn_t       e_rs2 [2];
   rn_t       e_rd  [2];

   function automatic void model_reset();
      for (int i = 0; i < ARCH_REGS; i++) begin
         m_map[i]  = '0;
         m_snap[i] = '0;
      end
      for (int t = 0; t < RN_TAGS; t++) begin
         m_busy[t]  = (t == 0);
         m_spec[t]  = 1'b0;
         m_owner[t] = '0;
      end
      m_snap_valid = 1'b0;
   endfunction

   function automatic rn_t m_src(int i, arch_reg_t r, bit nd0, rn_t a0);
      if (r == 0) return RN_NONE;
      if (i == 1 && nd0 && r == bus.q_rd[0]) return a0;
      return m_map[r];
   endfunction

   // One clock of the rename rules, evaluated on the inputs now driven.
   function automatic void model_eval();
      int  fl[$];
      bit  nd [2];
      rn_t a  [2];
      int  k;
      bit  acc, eff, take;
      for (int t = 1; t < RN_TAGS; t++)
         if (!m_busy[t]) fl.push_back(t);
      for (int i = 0; i < 2; i++)
         nd[i] = bus.q_valid[i] && bus.q_rename[i] && bus.q_rd[i] != 0;
      e_full = fl.size() < (int'(nd[0]) + int'(nd[1]));
      eff = flush && m_snap_valid;
      acc = !e_full && !eff;
      k = 0;
      for (int i = 0; i < 2; i++) begin
         a[i] = RN_NONE;
         if (nd[i] && acc) begin
            a[i] = rn_t'(fl[k]);
            k++;
         end
      end
      for (int i = 0; i < 2; i++) begin
         e_rv[i]  = bus.q_valid[i] && acc;
         e_rs1[i] = e_rv[i] ? m_src(i, bus.q_rs_1[i], nd[0], a[0]) : '0;
         e_rs2[i] = e_rv[i] ? m_src(i, bus.q_rs_2[i], nd[0], a[0]) : '0;
         e_rd[i]  = e_rv[i] ? a[i] : '0;
      end
      for (int p = 0; p < 2; p++) begin
         if (commit_valid[p] && commit_rn[p] != 0) begin
            if (m_map[commit_rd[p]] == commit_rn[p]) m_map[commit_rd[p]] = '0;
            if (m_snap[commit_rd[p]] == commit_rn[p]) m_snap[commit_rd[p]] = '0;
            m_busy[commit_rn[p]] = 1'b0;
            m_spec[commit_rn[p]] = 1'b0;
         end
      end
      if (eff) begin
         m_map = m_snap;
         for (int t = 0; t < RN_TAGS; t++) begin
            if (m_spec[t]) m_busy[t] = 1'b0;
            m_spec[t] = 1'b0;
         end
         m_snap_valid = 1'b0;
      end else begin
         take = tag_set && !tag_clear && !m_snap_valid;
         if (take) m_snap = m_map;
         for (int i = 0; i < 2; i++) begin
            if (nd[i] && acc) begin
               m_map[bus.q_rd[i]] = a[i];
               m_busy[a[i]]  = 1'b1;
               m_owner[a[i]] = bus.q_rd[i];
               if (bus.q_tag[i]) m_spec[a[i]] = 1'b1;
               if (take && !bus.q_tag[i]) m_snap[bus.q_rd[i]] = a[i];
            end
         end
         if (tag_clear) begin
            for (int t = 0; t < RN_TAGS; t++) m_spec[t] = 1'b0;
            m_snap_valid = 1'b0;
         end else if (take) begin
            m_snap_valid = 1'b1;
         end
      end
   endfunction

   task automatic clear_inputs();
      for (int i = 0; i < 2; i++) begin
         bus.q_valid[i]  = 1'b0;
         bus.q_rs_1[i]   = '0;
         bus.q_rs_2[i]   = '0;
         bus.q_rd[i]     = '0;
         bus.q_rename[i] = 1'b0;
         bus.q_tag[i]    = 1'b0;
         commit_valid[i] = 1'b0;
         commit_rd[i]    = '0;
         commit_rn[i]    = '0;
      end
      tag_set   = 1'b0;
      tag_clear = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic set_q(input int i, input logic v, input arch_reg_t r1,
                        input arch_reg_t r2, input arch_reg_t rd,
                        input logic ren, input logic tg);
      bus.q_valid[i]  = v;
      bus.q_rs_1[i]   = r1;
      bus.q_rs_2[i]   = r2;
      bus.q_rd[i]     = rd;
      bus.q_rename[i] = ren;
      bus.q_tag[i]    = tg;
   endtask

   task automatic tick();
      model_eval();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++; if (bus.r_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rv0 got=%0b want=0", bus.r_valid[0]); end
      checks++; if (bus.r_valid[1] !== 1'b0) begin errors++; $display("FAIL reset_rv1 got=%0b want=0", bus.r_valid[1]); end
      checks++; if (bus.r_rd_rn[0] !== 6'd0) begin errors++; $display("FAIL reset_rd0 got=%0d want=0", bus.r_rd_rn[0]); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b want=0", bus.full); end
      reset = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      set_q(0, 1, 5'd1, 5'd2, 5'd3, 1, 0);
      tick();
      checks++; if (bus.r_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_rv0 got=%0b want=1", bus.r_valid[0]); end
      checks++; if (bus.r_valid[1] !== 1'b0) begin errors++; $display("FAIL basic_rv1 got=%0b want=0", bus.r_valid[1]); end
      checks++; if (bus.r_rs_1_rn[0] !== 6'd0) begin errors++; $display("FAIL basic_rs1 got=%0d want=0", bus.r_rs_1_rn[0]); end
      checks++; if (bus.r_rs_2_rn[0] !== 6'd0) begin errors++; $display("FAIL basic_rs2 got=%0d want=0", bus.r_rs_2_rn[0]); end
      checks++; if (bus.r_rd_rn[0] !== 6'd1) begin errors++; $display("FAIL basic_rd got=%0d want=1", bus.r_rd_rn[0]); end
   endtask

   task automatic test_pair_forward();
      do_reset();
      set_q(0, 1, 5'd0, 5'd0, 5'd5, 1, 0);
      set_q(1, 1, 5'd5, 5'd0, 5'd5, 1, 0);
      tick();
      checks++; if (bus.r_rd_rn[0] !== 6'd1) begin errors++; $display("FAIL fwd_rd0 got=%0d want=1", bus.r_rd_rn[0]); end
      checks++; if (bus.r_rs_1_rn[1] !== 6'd1) begin errors++; $display("FAIL fwd_rs1 got=%0d want=1", bus.r_rs_1_rn[1]); end
      checks++; if (bus.r_rd_rn[1] !== 6'd2) begin errors++; $display("FAIL fwd_rd1 got=%0d want=2", bus.r_rd_rn[1]); end
      clear_inputs();
      set_q(0, 1, 5'd5, 5'd0, 5'd0, 0, 0);
      tick();
      checks++; if (bus.r_rs_1_rn[0] !== 6'd2) begin errors++; $display("FAIL fwd_map5 got=%0d want=2", bus.r_rs_1_rn[0]); end
   endtask

   task automatic test_full();
      do_reset();
      for (int c = 0; c < 31; c++) begin
         set_q(0, 1, 5'd0, 5'd0, arch_reg_t'(c + 1), 1, 0);
         set_q(1, 1, 5'd0, 5'd0, arch_reg_t'(31 - c), 1, 0);
         tick();
      end
      checks++; if (bus.r_rd_rn[1] !== 6'd62) begin errors++; $display("FAIL full_last got=%0d want=62", bus.r_rd_rn[1]); end
      #1;
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_set got=%0b want=1", bus.full); end
      tick();
      checks++; if (bus.r_valid[0] !== 1'b0 || bus.r_valid[1] !== 1'b0) begin errors++; $display("FAIL full_refuse got=%0b%0b want=00", bus.r_valid[0], bus.r_valid[1]); end
      commit_valid[0] = 1'b1;
      commit_rd[0]    = 5'd1;
      commit_rn[0]    = 6'd10;
      #1;
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_same_cycle got=%0b want=1", bus.full); end
      tick();
      commit_valid[0] = 1'b0;
      #1;
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_release got=%0b want=0", bus.full); end
      tick();
      checks++; if (bus.r_rd_rn[0] !== 6'd10) begin errors++; $display("FAIL full_reuse0 got=%0d want=10", bus.r_rd_rn[0]); end
      checks++; if (bus.r_rd_rn[1] !== 6'd63) begin errors++; $display("FAIL full_reuse1 got=%0d want=63", bus.r_rd_rn[1]); end
   endtask

   task automatic test_reset_mid();
      checks++; if (bus.r_valid[0] !== 1'b1) begin errors++; $display("FAIL mid_pending got=%0b want=1", bus.r_valid[0]); end
      #1;
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL mid_full_pre got=%0b want=1", bus.full); end
      reset = 1'b0;
      #1;
      checks++; if (bus.r_valid[0] !== 1'b0 || bus.r_valid[1] !== 1'b0) begin errors++; $display("FAIL mid_rv got=%0b%0b want=00", bus.r_valid[0], bus.r_valid[1]); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL mid_full got=%0b want=0", bus.full); end
      reset = 1'b1;
      model_reset();
      clear_inputs();
      set_q(0, 1, 5'd0, 5'd0, 5'd3, 1, 0);
      tick();
      checks++; if (bus.r_rd_rn[0] !== 6'd1) begin errors++; $display("FAIL mid_first_rn got=%0d want=1", bus.r_rd_rn[0]); end
   endtask

   task automatic test_flush();
      do_reset();
      tag_set = 1'b1;
      set_q(0, 1, 5'd0, 5'd0, 5'd4, 1, 0);
      tick();
      checks++; if (bus.r_rd_rn[0] !== 6'd1) begin errors++; $display("FAIL flush_untagged got=%0d want=1", bus.r_rd_rn[0]); end
      tag_set = 1'b0;
      set_q(0, 1, 5'd0, 5'd0, 5'd4, 1, 1);
      tick();
      checks++; if (bus.r_rd_rn[0] !== 6'd2) begin errors++; $display("FAIL flush_tagged got=%0d want=2", bus.r_rd_rn[0]); end
      flush = 1'b1;
      set_q(0, 1, 5'd4, 5'd0, 5'd9, 1, 0);
      tick();
      checks++; if (bus.r_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_refuse got=%0b want=0", bus.r_valid[0]); end
      flush = 1'b0;
      set_q(0, 1, 5'd4, 5'd0, 5'd7, 1, 0);
      tick();
      checks++; if (bus.r_rs_1_rn[0] !== 6'd1) begin errors++; $display("FAIL flush_map4 got=%0d want=1", bus.r_rs_1_rn[0]); end
      checks++; if (bus.r_rd_rn[0] !== 6'd2) begin errors++; $display("FAIL flush_realloc got=%0d want=2", bus.r_rd_rn[0]); end
   endtask

   task automatic fill_six();
      set_q(0, 1, 5'd0, 5'd0, 5'd1, 1, 0);
      set_q(1, 1, 5'd0, 5'd0, 5'd2, 1, 0);
      tick();
      set_q(0, 1, 5'd0, 5'd0, 5'd6, 1, 0);
      set_q(1, 1, 5'd0, 5'd0, 5'd8, 1, 0);
      tick();
      set_q(0, 1, 5'd0, 5'd0, 5'd9, 1, 0);
      set_q(1, 1, 5'd0, 5'd0, 5'd10, 1, 0);
      tick();
      clear_inputs();
   endtask

   task automatic test_commit();
      do_reset();
      fill_six();
      commit_valid[0] = 1'b1;
      commit_rd[0]    = 5'd6;
      commit_rn[0]    = 6'd3;
      set_q(0, 1, 5'd6, 5'd0, 5'd11, 1, 0);
      tick();
      checks++; if (bus.r_rs_1_rn[0] !== 6'd3) begin errors++; $display("FAIL commit_pre got=%0d want=3", bus.r_rs_1_rn[0]); end
      checks++; if (bus.r_rd_rn[0] !== 6'd7) begin errors++; $display("FAIL commit_noreuse got=%0d want=7", bus.r_rd_rn[0]); end
      clear_inputs();
      set_q(0, 1, 5'd6, 5'd0, 5'd0, 0, 0);
      tick();
      checks++; if (bus.r_rs_1_rn[0] !== 6'd0) begin errors++; $display("FAIL commit_clear got=%0d want=0", bus.r_rs_1_rn[0]); end
      do_reset();
      fill_six();
      set_q(0, 1, 5'd0, 5'd0, 5'd6, 1, 0);
      tick();
      clear_inputs();
      commit_valid[0] = 1'b1;
      commit_rd[0]    = 5'd6;
      commit_rn[0]    = 6'd3;
      tick();
      clear_inputs();
      set_q(0, 1, 5'd6, 5'd0, 5'd0, 0, 0);
      set_q(1, 1, 5'd0, 5'd0, 5'd12, 1, 0);
      tick();
      checks++; if (bus.r_rs_1_rn[0] !== 6'd7) begin errors++; $display("FAIL commit_keep got=%0d want=7", bus.r_rs_1_rn[0]); end
      checks++; if (bus.r_rd_rn[1] !== 6'd3) begin errors++; $display("FAIL commit_freed got=%0d want=3", bus.r_rd_rn[1]); end
   endtask

   task automatic test_random();
      int t;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 2; i++) begin
            set_q(i, $urandom_range(0, 3) != 0,
                  arch_reg_t'($urandom_range(0, 31)),
                  arch_reg_t'($urandom_range(0, 31)),
                  arch_reg_t'($urandom_range(0, 31)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) != 0);
         end
         tag_set   = $urandom_range(0, 9) == 0;
         tag_clear = $urandom_range(0, 29) == 0;
         flush     = $urandom_range(0, 19) == 0;
         for (int p = 0; p < 2; p++) begin
            commit_valid[p] = 1'b0;
            commit_rd[p]    = '0;
            commit_rn[p]    = '0;
            if ($urandom_range(0, 99) < 45) begin
               for (int k = 0; k < 8; k++) begin
                  t = $urandom_range(1, 63);
                  if (m_busy[t] && !(p == 1 && commit_valid[0] && commit_rn[0] == rn_t'(t))) begin
                     commit_valid[p] = 1'b1;
                     commit_rn[p]    = rn_t'(t);
                     commit_rd[p]    = ($urandom_range(0, 3) == 0) ? arch_reg_t'($urandom_range(0, 31)) : m_owner[t];
                     break;
                  end
               end
            end
         end
         #1;
         model_eval();
         checks++; if (bus.full !== e_full) begin errors++; $display("FAIL rnd_full n=%0d got=%0b want=%0b", n, bus.full, e_full); end
         @(posedge clock);
         #1;
         for (int i = 0; i < 2; i++) begin
            checks++; if (bus.r_valid[i] !== e_rv[i]) begin errors++; $display("FAIL rnd_rv%0d n=%0d got=%0b want=%0b", i, n, bus.r_valid[i], e_rv[i]); end
            checks++; if (bus.r_rs_1_rn[i] !== e_rs1[i]) begin errors++; $display("FAIL rnd_rs1_%0d n=%0d got=%0d want=%0d", i, n, bus.r_rs_1_rn[i], e_rs1[i]); end
            checks++; if (bus.r_rs_2_rn[i] !== e_rs2[i]) begin errors++; $display("FAIL rnd_rs2_%0d n=%0d got=%0d want=%0d", i, n, bus.r_rs_2_rn[i], e_rs2[i]); end
            checks++; if (bus.r_rd_rn[i] !== e_rd[i]) begin errors++; $display("FAIL rnd_rd%0d n=%0d got=%0d want=%0d", i, n, bus.r_rd_rn[i], e_rd[i]); end
         end
      end
      clear_inputs();
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_pair_forward();
      test_full();
      test_reset_mid();
      test_flush();
      test_commit();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
